// File: rtl/input_conditioner_pkg.sv
// Shared types and defaults for the switch/button input conditioner.
// Holds the per-channel debounce state encoding and the default build parameters.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } deb_state_t;

  localparam int         CHANNELS_DEFAULT    = 4;
  localparam int         DEBOUNCE_DEFAULT    = 1_000_000;
  localparam logic [3:0] TOGGLE_MASK_DEFAULT = 4'b0010;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioned input: 2-flop synchronizer, debounce FSM with stability counter,
// and registered level / rise / fall / toggle outputs.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DebounceCycles = DEBOUNCE_DEFAULT,
  parameter bit ToggleEn       = 1'b0
) (
  input  logic i_clock_50mhz,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_toggle
);

  localparam int              CntW    = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            r_sync1;
  logic            r_sync2;
  deb_state_t      r_state;
  deb_state_t      w_state_next;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic            w_accept_rise;
  logic            w_accept_fall;
  logic            r_level;
  logic            r_rise;
  logic            r_fall;
  logic            r_toggle;

  always_ff @(posedge i_clock_50mhz or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= STABLE_LOW;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Counter restarts on every entry to or exit from a WAIT state, so it never wraps.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      STABLE_LOW: begin
        if (r_sync2) begin
          w_state_next = WAIT_HIGH;
          w_cnt_next   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!r_sync2) begin
          w_state_next = STABLE_LOW;
          w_cnt_next   = '0;
        end else if (r_cnt == CntLast) begin
          w_state_next = STABLE_HIGH;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CntOne;
        end
      end
      STABLE_HIGH: begin
        if (!r_sync2) begin
          w_state_next = WAIT_LOW;
          w_cnt_next   = '0;
        end
      end
      WAIT_LOW: begin
        if (r_sync2) begin
          w_state_next = STABLE_HIGH;
          w_cnt_next   = '0;
        end else if (r_cnt == CntLast) begin
          w_state_next = STABLE_LOW;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CntOne;
        end
      end
      default: begin
        w_state_next = STABLE_LOW;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    w_accept_rise = (r_state == WAIT_HIGH) && r_sync2 && (r_cnt == CntLast);
    w_accept_fall = (r_state == WAIT_LOW) && !r_sync2 && (r_cnt == CntLast);
  end

  always_ff @(posedge i_clock_50mhz or posedge i_reset) begin
    if (i_reset) begin
      r_level  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_rise <= w_accept_rise;
      r_fall <= w_accept_fall;
      if (w_accept_rise) begin
        r_level <= 1'b1;
      end else if (w_accept_fall) begin
        r_level <= 1'b0;
      end
      r_toggle <= ToggleEn ? (r_toggle ^ w_accept_rise) : 1'b0;
    end
  end

  assign o_level  = r_level;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_toggle = r_toggle;

endmodule

// File: rtl/input_conditioner.sv
// Board input conditioner: one independent debounce channel per raw switch/button.
// Bit order feeds the downstream i_set, i_pause, i_count, i_type inputs directly.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int                  Channels       = CHANNELS_DEFAULT,
  parameter int                  DebounceCycles = DEBOUNCE_DEFAULT,
  parameter logic [Channels-1:0] ToggleMask     = Channels'(TOGGLE_MASK_DEFAULT)
) (
  input  logic                i_clock_50mhz,
  input  logic                i_reset,
  input  logic [Channels-1:0] i_raw,
  output logic [Channels-1:0] o_level,
  output logic [Channels-1:0] o_rise,
  output logic [Channels-1:0] o_fall,
  output logic [Channels-1:0] o_toggle
);

  genvar gi;
  generate
    for (gi = 0; gi < Channels; gi++) begin : g_ch
      debounce_channel #(
        .DebounceCycles(DebounceCycles),
        .ToggleEn      (ToggleMask[gi])
      ) u_ch (
        .i_clock_50mhz(i_clock_50mhz),
        .i_reset      (i_reset),
        .i_raw        (i_raw[gi]),
        .o_level      (o_level[gi]),
        .o_rise       (o_rise[gi]),
        .o_fall       (o_fall[gi]),
        .o_toggle     (o_toggle[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DebounceCycles=4: stimulus pushes expected
// pulse events (cycle, level, rise, fall, toggle); a monitor pops them when pulses appear.
module tb_input_conditioner;

  localparam int LAT = 7;  // drive at negedge of cycle c, first sample at c+1, accept at c+1+6

  typedef struct {
    int         cyc;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] toggle;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [3:0] i_raw;
  logic [3:0] o_level, o_rise, o_fall, o_toggle;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   t, t2;

  input_conditioner #(
    .Channels      (4),
    .DebounceCycles(4),
    .ToggleMask    (4'b0010)
  ) dut (
    .i_clock_50mhz(clk),
    .i_reset      (i_reset),
    .i_raw        (i_raw),
    .o_level      (o_level),
    .o_rise       (o_rise),
    .o_fall       (o_fall),
    .o_toggle     (o_toggle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] l, input logic [3:0] r,
                      input logic [3:0] f, input logic [3:0] tg);
    exp_t e;
    e.cyc = c; e.level = l; e.rise = r; e.fall = f; e.toggle = tg;
    sb.push_back(e);
  endtask

  task automatic set_raw(input logic [3:0] v, output int tc);
    @(negedge clk);
    i_raw = v;
    tc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL %s: %0d expected events never seen (required 0)", name, sb.size());
      sb.delete();
    end else begin
      $display("ok   %s: all expected events seen", name);
    end
  endtask

  task automatic check_zero(input string name);
    n_checks += 4;
    if (o_level !== 4'b0) begin n_errors++; $display("FAIL %s level: got %b required 0000", name, o_level); end
    if (o_rise !== 4'b0) begin n_errors++; $display("FAIL %s rise: got %b required 0000", name, o_rise); end
    if (o_fall !== 4'b0) begin n_errors++; $display("FAIL %s fall: got %b required 0000", name, o_fall); end
    if (o_toggle !== 4'b0) begin n_errors++; $display("FAIL %s toggle: got %b required 0000", name, o_toggle); end
    $display("ok   %s: outputs checked for zero", name);
  endtask

  // Monitor: every pulse cycle must match the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (i_reset === 1'b0 && (o_rise | o_fall) !== 4'b0) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_event: cyc=%0d rise=%b fall=%b level=%b toggle=%b, required none",
                 cyc, o_rise, o_fall, o_level, o_toggle);
      end else begin
        mon_e = sb.pop_front();
        if (cyc != mon_e.cyc || o_level !== mon_e.level || o_rise !== mon_e.rise ||
            o_fall !== mon_e.fall || o_toggle !== mon_e.toggle) begin
          n_errors++;
          $display("FAIL event: got cyc=%0d lvl=%b rise=%b fall=%b tog=%b required cyc=%0d lvl=%b rise=%b fall=%b tog=%b",
                   cyc, o_level, o_rise, o_fall, o_toggle,
                   mon_e.cyc, mon_e.level, mon_e.rise, mon_e.fall, mon_e.toggle);
        end else begin
          $display("ok   event cyc=%0d lvl=%b rise=%b fall=%b tog=%b",
                   cyc, o_level, o_rise, o_fall, o_toggle);
        end
      end
    end
  end

  initial begin
    i_reset = 1'b0;
    i_raw   = 4'b0000;
    #2 i_reset = 1'b1;
    #1 check_zero("power_on_reset");
    idle(3);
    i_reset = 1'b0;
    idle(3);

    // Clean press and release on channel 0.
    set_raw(4'b0001, t); push(t + LAT, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    idle(10); check_drained("clean_press");
    set_raw(4'b0000, t); push(t + LAT, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    idle(10); check_drained("clean_release");

    // Bounce: high 3, low 1, then held high.
    set_raw(4'b0001, t); idle(2);
    set_raw(4'b0000, t);
    set_raw(4'b0001, t); push(t + LAT, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    idle(12); check_drained("bounce_press");
    set_raw(4'b0000, t); push(t + LAT, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    idle(10); check_drained("bounce_release");

    // Boundary: high for 4 sampled cycles is rejected (drops on the deciding cycle).
    set_raw(4'b0001, t); idle(3);
    set_raw(4'b0000, t);
    idle(12); check_drained("boundary_reject");

    // Boundary: high for 5 sampled cycles is accepted, then released.
    set_raw(4'b0001, t); push(t + LAT, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    idle(4);
    set_raw(4'b0000, t2); push(t2 + LAT, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    idle(12); check_drained("boundary_accept");

    // Toggle on channel 1: two press/release cycles.
    for (int k = 0; k < 2; k++) begin
      set_raw(4'b0010, t);
      push(t + LAT, 4'b0010, 4'b0010, 4'b0000, (k == 0) ? 4'b0010 : 4'b0000);
      idle(10);
      set_raw(4'b0000, t);
      push(t + LAT, 4'b0000, 4'b0000, 4'b0010, (k == 0) ? 4'b0010 : 4'b0000);
      idle(10);
    end
    check_drained("toggle_ch1");

    // Channels 1 and 3 high, then reset mid-wait on channel 2.
    set_raw(4'b1010, t); push(t + LAT, 4'b1010, 4'b1010, 4'b0000, 4'b0010);
    idle(10); check_drained("pair_press");
    set_raw(4'b1110, t);
    idle(4);
    i_reset = 1'b1;
    #1 check_zero("reset_mid_wait");
    idle(2);
    i_reset = 1'b0;
    t = cyc;
    push(t + LAT, 4'b1110, 4'b1110, 4'b0000, 4'b0010);
    idle(12); check_drained("held_through_reset");

    // Release all, then all four rise together.
    set_raw(4'b0000, t); push(t + LAT, 4'b0000, 4'b0000, 4'b1110, 4'b0010);
    idle(10);
    set_raw(4'b1111, t); push(t + LAT, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    idle(10); check_drained("parallel_rise");

    // Release channel 3 from stable high.
    set_raw(4'b0111, t); push(t + LAT, 4'b0111, 4'b0000, 4'b1000, 4'b0000);
    idle(12); check_drained("release_ch3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter Channels, default 4, number of switch/button channels conditioned (set, pause, count, type).
REQ-002 Parameter DebounceCycles, default 1_000_000, consecutive stable clock cycles required to accept a change (20 ms at 50 MHz); legal range 2..2^24.
REQ-003 Parameter ToggleMask, default 4'b0010, per-channel enable of press-to-toggle output (bit 1 = pause).
REQ-004 i_clock_50mhz  input  1  sole clock, 50 MHz.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_raw  input  Channels  raw asynchronous board inputs, active-high.
REQ-007 o_level  output  Channels  debounced level per channel.
REQ-008 o_rise  output  Channels  one-cycle pulse on accepted 0->1 transition.
REQ-009 o_fall  output  Channels  one-cycle pulse on accepted 1->0 transition.
REQ-010 o_toggle  output  Channels  toggle state, inverts on each accepted rise where ToggleMask bit set; constant 0 where clear.

Function
REQ-011 Each i_raw bit SHALL pass a 2-flop synchronizer before any other logic; no combinational path from i_raw to any output.
REQ-012 Each channel SHALL run an independent FSM: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
REQ-013 STABLE_LOW: synchronized input 1 -> WAIT_HIGH, counter cleared to 0; else stay.
REQ-014 WAIT_HIGH: synchronized input 0 -> STABLE_LOW, counter cleared, no output change (bounce rejected); input 1 -> counter increments.
REQ-015 WAIT_HIGH with counter = DebounceCycles-1 and input 1 -> STABLE_HIGH; o_level goes 1 and o_rise pulses on the same following clock edge.
REQ-016 STABLE_HIGH / WAIT_LOW SHALL mirror REQ-013..015 with polarity inverted, producing o_fall.
REQ-017 Latency: a clean raw edge SHALL appear on o_level exactly DebounceCycles+2 clock cycles after first sampled.
REQ-018 o_rise and o_fall SHALL be high for exactly one cycle per accepted transition, never simultaneously on one channel.
REQ-019 o_toggle SHALL update on the same edge as o_rise for masked channels.
REQ-020 Counter width SHALL be $clog2(DebounceCycles); counter SHALL never wrap (it is cleared on exit from WAIT states).
REQ-021 A bounce arriving on the exact cycle the counter reaches DebounceCycles-1 SHALL reject the change (input value at that cycle decides).
REQ-022 Simultaneous transitions on several channels SHALL be handled independently with identical latency.
REQ-023 Outputs o_level, o_rise, o_fall, o_toggle SHALL be registered.

Reset
REQ-024 i_reset asserted SHALL immediately force: synchronizer flops 0, all FSMs STABLE_LOW, counters 0, o_level 0, o_rise 0, o_fall 0, o_toggle 0.
REQ-025 A raw input held high through reset release SHALL be accepted as a rise DebounceCycles+2 cycles after release (one o_rise pulse).
REQ-026 Reset asserted mid-WAIT SHALL discard the partial count; no pulse emitted.

Structure
REQ-027 Shared package input_conditioner_pkg SHALL hold the FSM state enum and default constants (DEBOUNCE_DEFAULT, TOGGLE_MASK_DEFAULT).
REQ-028 Per-channel logic (synchronizer, FSM, counter, pulse/toggle) SHALL be sub-module debounce_channel, instantiated Channels times via generate.
REQ-029 Outputs SHALL connect directly to the downstream top-level inputs i_set, i_pause, i_count, i_type.

Verification (DebounceCycles=4 for simulation)
REQ-030 Clean press: i_raw[0] 0->1 held -> o_level[0]=1 and o_rise[0] single pulse at cycle 6 after change; o_fall silent.
REQ-031 Bounce: i_raw[0] high 3 cycles, low 1, high held -> no output during bounce; o_level[0] rises 6 cycles after final rise.
REQ-032 Toggle: two clean press/release cycles on channel 1 -> o_toggle[1] goes 1 then 0; channel 0 o_toggle stays 0.
REQ-033 Reset mid-wait: i_raw[2] high, i_reset asserted at cycle 4 for 2 cycles -> all outputs 0 immediately; one o_rise[2] 6 cycles after release.
REQ-034 Parallel: all four i_raw rise same cycle -> o_rise=4'b1111 for exactly one cycle, 6 cycles later.
REQ-035 Release: from stable high, i_raw[3] 1->0 -> o_fall[3] single pulse and o_level[3]=0 at cycle 6.
